// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_BOOT,
    ARB_RELEASE,
    ARB_RUN
  } arb_state_t;

  localparam int unsigned BOOT_CNT_W = 16;
  localparam logic [BOOT_CNT_W-1:0] BOOT_CNT_MAX = '1;

endpackage

// File: rtl/mem_arbiter.sv
// Boot sequencer and memory-port arbiter between the 6502 core and the loader.
// Boot: loader owns the port with the CPU held in reset. Release: timed CPU
// reset pulse. Run: CPU owns the port; loader steals isolated read cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int RES_HOLD   = 8
) (
  input  logic                  PHI_2,
  input  logic                  RES,
  input  logic [ADDR_WIDTH-1:0] AB,
  input  logic [DATA_WIDTH-1:0] DB_OUT,
  input  logic                  RW,
  output logic [DATA_WIDTH-1:0] DB_IN,
  output logic                  RDY,
  output logic                  CPU_RES_N,
  input  logic                  LD_VALID,
  output logic                  LD_READY,
  input  logic [ADDR_WIDTH-1:0] LD_ADDR,
  input  logic [DATA_WIDTH-1:0] LD_DATA,
  input  logic                  LD_DONE,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dina,
  input  logic [DATA_WIDTH-1:0] douta,
  output logic [BOOT_CNT_W-1:0] BOOT_CNT
);

  localparam logic [7:0] HOLD_LAST = 8'(RES_HOLD - 1);

  arb_state_t            state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic                  steal_q, steal_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic                  res_dly_q;

  logic                  gate;
  logic                  grant;
  logic                  ld_ready;

  // Outputs are forced to their reset values during RES and the cycle after.
  assign gate  = RES | res_dly_q;
  assign DB_IN = douta;

  // State, hold counter, steal flag, boot counter and reset-delay registers.
  always_ff @(posedge PHI_2) begin
    if (RES) begin
      state_q    <= ARB_BOOT;
      hold_q     <= '0;
      steal_q    <= 1'b0;
      boot_cnt_q <= '0;
      res_dly_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      steal_q    <= steal_d;
      boot_cnt_q <= boot_cnt_d;
      res_dly_q  <= 1'b0;
    end
  end

  // Next-state, hold counter, steal flag and saturating boot counter.
  always_comb begin
    state_d    = state_q;
    hold_d     = '0;
    steal_d    = grant;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      ARB_BOOT: begin
        if (LD_DONE) state_d = ARB_RELEASE;
        if (LD_VALID && ld_ready && (boot_cnt_q != BOOT_CNT_MAX))
          boot_cnt_d = boot_cnt_q + 1'b1;
      end
      ARB_RELEASE: begin
        if (hold_q == HOLD_LAST) state_d = ARB_RUN;
        else                     hold_d  = hold_q + 1'b1;
      end
      ARB_RUN: state_d = ARB_RUN;
      default: state_d = ARB_BOOT;
    endcase
  end

  // Port mux, CPU control and loader handshake, combinational for zero-latency grants.
  always_comb begin
    CPU_RES_N = 1'b0;
    RDY       = 1'b0;
    ld_ready  = 1'b0;
    ena       = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    grant     = 1'b0;
    if (!gate) begin
      case (state_q)
        ARB_BOOT: begin
          ld_ready = 1'b1;
          ena      = LD_VALID;
          wea      = LD_VALID;
          addra    = LD_ADDR;
          dina     = LD_DATA;
        end
        ARB_RUN: begin
          CPU_RES_N = 1'b1;
          // Only CPU reads are stolen, never twice in a row.
          grant = LD_VALID & RW & ~steal_q;
          ena   = 1'b1;
          if (grant) begin
            wea      = 1'b1;
            addra    = LD_ADDR;
            dina     = LD_DATA;
            ld_ready = 1'b1;
          end else begin
            wea   = ~RW;
            addra = AB;
            dina  = DB_OUT;
            RDY   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign LD_READY = ld_ready;
  assign BOOT_CNT = gate ? '0 : boot_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-cycle expectations are queued when
// stimulus is applied and compared against the DUT on the falling edge.
module tb_mem_arbiter;

  localparam int RH = 8;

  logic        clk;
  logic        res;
  logic [15:0] ab;
  logic [7:0]  db_out;
  logic        rw;
  logic [7:0]  db_in;
  logic        rdy;
  logic        cpu_res_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_done;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [7:0]  dina;
  logic [7:0]  douta;
  logic [15:0] boot_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic        cres;
    logic        rdy;
    logic        ldr;
    logic        en;
    logic        we;
    logic [15:0] ad;
    logic [7:0]  di;
    logic [15:0] bc;
    logic        pchk;
    logic [7:0]  dbi;
  } exp_t;

  exp_t exp_q[$];

  mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .RES_HOLD  (RH)
  ) dut (
    .PHI_2    (clk),
    .RES      (res),
    .AB       (ab),
    .DB_OUT   (db_out),
    .RW       (rw),
    .DB_IN    (db_in),
    .RDY      (rdy),
    .CPU_RES_N(cpu_res_n),
    .LD_VALID (ld_valid),
    .LD_READY (ld_ready),
    .LD_ADDR  (ld_addr),
    .LD_DATA  (ld_data),
    .LD_DONE  (ld_done),
    .ena      (ena),
    .wea      (wea),
    .addra    (addra),
    .dina     (dina),
    .douta    (douta),
    .BOOT_CNT (boot_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare the DUT against the oldest queued expectation, mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".cpu_res_n"}, 32'(cpu_res_n), 32'(e.cres));
      check({e.tag, ".rdy"},       32'(rdy),       32'(e.rdy));
      check({e.tag, ".ld_ready"},  32'(ld_ready),  32'(e.ldr));
      check({e.tag, ".ena"},       32'(ena),       32'(e.en));
      check({e.tag, ".wea"},       32'(wea),       32'(e.we));
      check({e.tag, ".boot_cnt"},  32'(boot_cnt),  32'(e.bc));
      check({e.tag, ".db_in"},     32'(db_in),     32'(e.dbi));
      if (e.pchk) begin
        check({e.tag, ".addra"}, 32'(addra), 32'(e.ad));
        check({e.tag, ".dina"},  32'(dina),  32'(e.di));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    douta = 8'($urandom);
  endtask

  task automatic expect_cycle(input string tag, input logic cres, input logic rd,
                              input logic ldr, input logic en, input logic we,
                              input logic [15:0] ad, input logic [7:0] di,
                              input logic [15:0] bc, input logic pchk);
    exp_t e;
    e.tag  = tag;  e.cres = cres; e.rdy = rd;  e.ldr = ldr; e.en = en;
    e.we   = we;   e.ad   = ad;   e.di  = di;  e.bc  = bc;  e.pchk = pchk;
    e.dbi  = douta;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic expect_reset(input string tag);
    expect_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h0000, 1'b1);
  endtask

  task automatic expect_release(input string tag, input logic [15:0] bc);
    expect_cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, bc, 1'b0);
  endtask

  initial begin
    res = 1'b1; ab = 16'h0000; db_out = 8'h00; rw = 1'b1;
    ld_valid = 1'b0; ld_addr = 16'h0000; ld_data = 8'h00; ld_done = 1'b0;
    douta = 8'h00;
    tick();

    // Reset with a pending loader write: suppressed, outputs at reset values.
    ld_valid = 1'b1; ld_addr = 16'h1234; ld_data = 8'h77;
    repeat (3) expect_reset("rst");
    res = 1'b0;
    expect_reset("rst_after");

    // Boot writes.
    ld_addr = 16'h0000; ld_data = 8'hA9;
    expect_cycle("boot0", 0, 0, 1, 1, 1, 16'h0000, 8'hA9, 16'd0, 1);
    ld_addr = 16'hFFFC; ld_data = 8'h00;
    expect_cycle("boot1", 0, 0, 1, 1, 1, 16'hFFFC, 8'h00, 16'd1, 1);
    ld_valid = 1'b0; ld_addr = 16'h1111; ld_data = 8'h3C;
    expect_cycle("boot_idle", 0, 0, 1, 0, 0, 16'h1111, 8'h3C, 16'd2, 1);

    // Write in the LD_DONE cycle is still accepted.
    ld_valid = 1'b1; ld_done = 1'b1; ld_addr = 16'h0010; ld_data = 8'h5A;
    expect_cycle("boot_done", 0, 0, 1, 1, 1, 16'h0010, 8'h5A, 16'd2, 1);

    // Release: RES_HOLD cycles with CPU in reset, loader refused.
    ld_done = 1'b0; ld_addr = 16'h4000; ld_data = 8'h11;
    for (int i = 0; i < RH; i++) expect_release("release", 16'd3);

    // Run: CPU owns the port, steals alternate with CPU reads.
    rw = 1'b1; ab = 16'h0200; db_out = 8'h99;
    expect_cycle("steal0", 1, 0, 1, 1, 1, 16'h4000, 8'h11, 16'd3, 1);
    ld_addr = 16'h4001; ld_data = 8'h22;
    expect_cycle("steal1", 1, 1, 0, 1, 0, 16'h0200, 8'h99, 16'd3, 1);
    expect_cycle("steal2", 1, 0, 1, 1, 1, 16'h4001, 8'h22, 16'd3, 1);
    ld_addr = 16'h4002; ld_data = 8'h33;
    expect_cycle("steal3", 1, 1, 0, 1, 0, 16'h0200, 8'h99, 16'd3, 1);
    ld_valid = 1'b0;
    expect_cycle("run_idle", 1, 1, 0, 1, 0, 16'h0200, 8'h99, 16'd3, 1);

    // CPU writes are never stolen.
    ld_valid = 1'b1; rw = 1'b0; ab = 16'h0300; db_out = 8'h55;
    expect_cycle("nosteal0", 1, 1, 0, 1, 1, 16'h0300, 8'h55, 16'd3, 1);
    expect_cycle("nosteal1", 1, 1, 0, 1, 1, 16'h0300, 8'h55, 16'd3, 1);
    rw = 1'b1;
    expect_cycle("steal_rd", 1, 0, 1, 1, 1, 16'h4002, 8'h33, 16'd3, 1);
    ld_valid = 1'b0;

    // Reset from run, then reset in the third release cycle.
    res = 1'b1;
    expect_reset("rst2");
    res = 1'b0;
    expect_reset("rst2_after");
    ld_valid = 1'b1; ld_addr = 16'h0100; ld_data = 8'hEE;
    expect_cycle("boot2", 0, 0, 1, 1, 1, 16'h0100, 8'hEE, 16'd0, 1);
    ld_valid = 1'b0; ld_done = 1'b1;
    expect_cycle("boot2_done", 0, 0, 1, 0, 0, 16'h0100, 8'hEE, 16'd1, 1);
    ld_done = 1'b0;
    expect_release("rel2_1", 16'd1);
    expect_release("rel2_2", 16'd1);
    res = 1'b1;
    expect_reset("rst_midrel");
    res = 1'b0;
    expect_reset("rst_midrel_after");
    for (int i = 0; i < RH + 4; i++)
      expect_cycle("reboot_hold", 0, 0, 1, 0, 0, 16'h0100, 8'hEE, 16'd0, 1);
    ld_done = 1'b1;
    expect_cycle("reboot_done", 0, 0, 1, 0, 0, 16'h0100, 8'hEE, 16'd0, 1);
    ld_done = 1'b0;
    for (int i = 0; i < RH; i++) expect_release("rel3", 16'd0);
    ab = 16'h0200; db_out = 8'h99;
    expect_cycle("run3", 1, 1, 0, 1, 0, 16'h0200, 8'h99, 16'd0, 1);

    // Boot counter saturation.
    res = 1'b1;
    tick();
    res = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 16'h2000; ld_data = 8'h42;
    repeat (65540) tick();
    expect_cycle("sat0", 0, 0, 1, 1, 1, 16'h2000, 8'h42, 16'hFFFF, 1);
    expect_cycle("sat1", 0, 0, 1, 1, 1, 16'h2000, 8'h42, 16'hFFFF, 1);

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and arbiter for the single memory_array port shared by the 6502 core and the program loader. After system reset it holds the CPU in reset while the loader fills memory. It then releases the CPU through a timed reset pulse. In normal running it hands the memory port to the CPU and lets the loader steal isolated CPU read cycles by pulling RDY low. It sits in the top level between proc, memory_array and the loader interface.

## Interface
- ADDR_WIDTH, 16, address bus width (CPU AB, loader, addra)
- DATA_WIDTH, 8, data width
- RES_HOLD, 8, cycles CPU_RES_N stays low after LD_DONE (legal range 2..255)
- PHI_2  in  1  clock; one clock, all logic on rising edge
- RES  in  1  reset; synchronous, active-high
- AB  in  ADDR_WIDTH  CPU address
- DB_OUT  in  DATA_WIDTH  CPU write data
- RW  in  1  CPU read(1)/write(0)
- DB_IN  out  DATA_WIDTH  CPU read data (= douta)
- RDY  out  1  CPU ready; 0 stalls the CPU
- CPU_RES_N  out  1  CPU reset, active-low, drives proc RES
- LD_VALID  in  1  loader write request
- LD_READY  out  1  loader write accepted this cycle
- LD_ADDR  in  ADDR_WIDTH  loader write address
- LD_DATA  in  DATA_WIDTH  loader write data
- LD_DONE  in  1  loader finished initial image (level or pulse)
- ena, wea  out  1 each  memory enable / write enable
- addra  out  ADDR_WIDTH  memory address
- dina  out  DATA_WIDTH  memory write data
- douta  in  DATA_WIDTH  memory read data, valid one cycle after a read
- BOOT_CNT  out  16  loader writes accepted in ARB_BOOT, saturates at 16'hFFFF

## Operation
- **States:**
  - ARB_BOOT is entered on RES. It moves to ARB_RELEASE on the first cycle LD_DONE=1.
  - ARB_RELEASE runs the hold counter from 0 to RES_HOLD-1, then moves to ARB_RUN.
  - ARB_RUN is terminal until RES.
- **ARB_BOOT:**
  - CPU_RES_N=0 and RDY=0.
  - LD_READY=1.
  - The memory port follows the loader: ena=wea=LD_VALID, addra=LD_ADDR, dina=LD_DATA.
  - BOOT_CNT increments on each LD_VALID&LD_READY.
  - An LD_VALID in the same cycle as LD_DONE is still accepted.
- **ARB_RELEASE:**
  - CPU_RES_N=0, RDY=0, LD_READY=0.
  - ena=wea=0.
- **ARB_RUN:**
  - CPU_RES_N=1.
  - By default the CPU owns the port: ena=1, wea=~RW, addra=AB, dina=DB_OUT, RDY=1, LD_READY=0.
  - The loader is granted only when all of these hold: LD_VALID=1, RW=1 (the 6502 ignores RDY on writes, so CPU writes are never stolen), and steal_last=0.
  - On a grant: ena=wea=1, addra=LD_ADDR, dina=LD_DATA, LD_READY=1, RDY=0, and steal_last is set for the next cycle.
  - steal_last clears after one cycle, which guarantees the CPU the cycle after every steal. No back-to-back steals occur, so loader throughput is at most one write per two cycles.
  - BOOT_CNT holds its value in ARB_RUN.
- DB_IN=douta always. The CPU re-presents the same read after a stolen cycle, so stale douta is never consumed.
- Loader handshake:
  - The loader holds LD_VALID/LD_ADDR/LD_DATA stable until LD_READY.
  - A write is transferred in the cycle where LD_VALID&LD_READY=1.
- RES at any time, including mid-boot or mid-release:
  - Next state is ARB_BOOT.
  - Hold counter, steal_last and BOOT_CNT clear.
  - The write in the RES cycle is suppressed.

## Timing
- **Reset values:** while RES=1 and on the cycle after, all outputs are held at: CPU_RES_N=0, RDY=0, LD_READY=0, ena=0, wea=0, addra=0, dina=0, BOOT_CNT=0. DB_IN follows douta.
- State and counters are registered. Port muxing, RDY and LD_READY are combinational from state, steal_last and the inputs, so there is zero-cycle grant latency.
- **Release timing:** LD_DONE sampled at edge N → ARB_RELEASE from N+1. CPU_RES_N rises at edge N+1+RES_HOLD.
- CPU read latency is one cycle (memory_array registered output). A stolen cycle adds exactly one cycle.

## Structure
- The shared package mem_arb_pkg holds:
  - typedef enum arb_state_t {ARB_BOOT, ARB_RELEASE, ARB_RUN}
  - the BOOT_CNT width constant
- Single module with no sub-module; the hold counter and steal flag are inline.

## Test plan
- **Reset then boot:** RES high 3 cycles → all outputs at reset values. Then loader writes 16'h0000=8'hA9 and 16'hFFFC=8'h00 → ena=wea=1 with matching addra/dina, LD_READY=1, BOOT_CNT=2.
- **Release timing:** LD_DONE pulse at cycle 10 with RES_HOLD=8 → CPU_RES_N=0 through cycle 18 and 1 from cycle 19. LD_VALID in ARB_RELEASE sees LD_READY=0.
- **Steal on read:** ARB_RUN, RW=1, AB=16'h0200, LD_VALID held 4 cycles → LD_READY/RDY=0 pattern 1/0,0/1,1/0,0/1. addra alternates LD_ADDR / 16'h0200. Loader gets 2 writes.
- **No steal on write:** RW=0, AB=16'h0300, DB_OUT=8'h55, LD_VALID=1 → wea=1, addra=16'h0300, dina=8'h55, LD_READY=0, RDY=1.
- **Reset mid-release:** RES asserted in cycle 3 of ARB_RELEASE → back to ARB_BOOT, BOOT_CNT=0. CPU_RES_N stays 0 until a fresh LD_DONE plus RES_HOLD.
- **BOOT_CNT saturation:** force 65536 accepted writes → BOOT_CNT stays 16'hFFFF.
